// File: rtl/mmcsr_axil_bridge_if.sv
// AXI4-Lite bus bundle between the interconnect master and the CSR bridge.
// The slave modport is the bridge side; the master modport is the driving side.
interface mmcsr_axil_bridge_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/mmcsr_axil_bridge.sv
// AXI4-Lite slave that turns each read or write into one held request on the
// CSR-file port, with address decode, write/read alternation and a request timeout.
module mmcsr_axil_bridge #(
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  mmcsr_axil_bridge_if.slave            s_axi,
  output logic [CSR_ADDR_WIDTH-1:0]     csr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] csr_wdata,
  output logic [3:0]                    csr_wstrb,
  output logic                          csr_we,
  output logic                          csr_re,
  input  logic                          csr_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] csr_rdata,
  input  logic                          csr_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    WR_RESP,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] UPPER_MASK =
    {C_S_AXI_ADDR_WIDTH{1'b1}} << (CSR_ADDR_WIDTH + 2);

  state_t                          state;
  logic                            last_write;
  logic [7:0]                      req_count;
  logic                            awready;
  logic                            wready;
  logic                            arready;
  logic                            bvalid;
  logic [1:0]                      bresp;
  logic                            rvalid;
  logic [1:0]                      rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;

  logic                            write_cand;
  logic                            read_cand;
  logic                            aw_decerr;
  logic                            ar_decerr;
  logic [CSR_ADDR_WIDTH-1:0]       aw_index;
  logic [CSR_ADDR_WIDTH-1:0]       ar_index;
  logic                            unused_prot;

  assign write_cand  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign read_cand   = s_axi.S_AXI_ARVALID;
  assign aw_decerr   = |(s_axi.S_AXI_AWADDR & UPPER_MASK);
  assign ar_decerr   = |(s_axi.S_AXI_ARADDR & UPPER_MASK);
  assign aw_index    = s_axi.S_AXI_AWADDR[CSR_ADDR_WIDTH+1:2];
  assign ar_index    = s_axi.S_AXI_ARADDR[CSR_ADDR_WIDTH+1:2];
  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RDATA   = rdata;

  // In IDLE a raised ready marks the grant cycle; the handshake completes on
  // the following edge, where the transaction is decoded and dispatched.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      last_write <= 1'b0;
      req_count  <= 8'd0;
      awready    <= 1'b0;
      wready     <= 1'b0;
      arready    <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      rvalid     <= 1'b0;
      rresp      <= RESP_OKAY;
      rdata      <= '0;
      csr_addr   <= '0;
      csr_wdata  <= '0;
      csr_wstrb  <= 4'd0;
      csr_we     <= 1'b0;
      csr_re     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awready) begin
            awready   <= 1'b0;
            wready    <= 1'b0;
            csr_addr  <= aw_index;
            csr_wdata <= s_axi.S_AXI_WDATA;
            csr_wstrb <= s_axi.S_AXI_WSTRB;
            if (aw_decerr) begin
              bresp  <= RESP_DECERR;
              bvalid <= 1'b1;
              state  <= WR_RESP;
            end else if (s_axi.S_AXI_WSTRB == 4'd0) begin
              bresp  <= RESP_OKAY;
              bvalid <= 1'b1;
              state  <= WR_RESP;
            end else begin
              csr_we    <= 1'b1;
              req_count <= 8'd0;
              state     <= WR_REQ;
            end
          end else if (arready) begin
            arready  <= 1'b0;
            csr_addr <= ar_index;
            if (ar_decerr) begin
              rresp  <= RESP_DECERR;
              rdata  <= '0;
              rvalid <= 1'b1;
              state  <= RD_RESP;
            end else begin
              csr_re    <= 1'b1;
              req_count <= 8'd0;
              state     <= RD_REQ;
            end
          end else if (write_cand && (!read_cand || !last_write)) begin
            awready    <= 1'b1;
            wready     <= 1'b1;
            last_write <= 1'b1;
          end else if (read_cand) begin
            arready    <= 1'b1;
            last_write <= 1'b0;
          end
        end

        WR_REQ: begin
          if (csr_ready) begin
            csr_we <= 1'b0;
            bresp  <= csr_err ? RESP_SLVERR : RESP_OKAY;
            bvalid <= 1'b1;
            state  <= WR_RESP;
          end else if (req_count == TIMEOUT_LAST) begin
            csr_we <= 1'b0;
            bresp  <= RESP_SLVERR;
            bvalid <= 1'b1;
            state  <= WR_RESP;
          end else begin
            req_count <= req_count + 8'd1;
          end
        end

        // A ready in the final timeout cycle takes precedence over the timeout.
        RD_REQ: begin
          if (csr_ready) begin
            csr_re <= 1'b0;
            rdata  <= csr_rdata;
            rresp  <= csr_err ? RESP_SLVERR : RESP_OKAY;
            rvalid <= 1'b1;
            state  <= RD_RESP;
          end else if (req_count == TIMEOUT_LAST) begin
            csr_re <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_SLVERR;
            rvalid <= 1'b1;
            state  <= RD_RESP;
          end else begin
            req_count <= req_count + 8'd1;
          end
        end

        WR_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        RD_RESP: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcsr_axil_bridge.sv
// Directed bench for mmcsr_axil_bridge: an AXI4-Lite master driven from one
// initial block plus a small CSR-file model with selectable ready/err behaviour.
module tb_mmcsr_axil_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_wstrb;
  logic        csr_we;
  logic        csr_re;
  logic        csr_ready;
  logic [31:0] csr_rdata;
  logic        csr_err;

  logic        ready_mode = 1'b1;
  logic        err_mode = 1'b0;
  logic [31:0] mem [16];

  int          compared = 0;
  int          mismatched = 0;
  int          we_cycles = 0;
  int          re_cycles = 0;
  logic [11:0] wr_log [$];
  bit          grant_log [$];

  mmcsr_axil_bridge_if #(.ADDR_WIDTH(16)) axi ();

  mmcsr_axil_bridge #(
    .C_S_AXI_ADDR_WIDTH(16),
    .C_S_AXI_DATA_WIDTH(32),
    .CSR_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .s_axi(axi.slave),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .csr_wstrb(csr_wstrb),
    .csr_we(csr_we),
    .csr_re(csr_re),
    .csr_ready(csr_ready),
    .csr_rdata(csr_rdata),
    .csr_err(csr_err)
  );

  always #5 ACLK = ~ACLK;

  assign csr_ready = ready_mode && (csr_we || csr_re);
  assign csr_err   = err_mode;
  assign csr_rdata = mem[csr_addr[3:0]];

  // CSR-file model storage, byte-lane write enables
  always @(posedge ACLK) begin
    if (csr_we && csr_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (csr_wstrb[b]) mem[csr_addr[3:0]][8*b +: 8] <= csr_wdata[8*b +: 8];
      end
    end
  end

  // Activity monitor: request cycles, completed write indices, grant order
  always @(posedge ACLK) begin
    if (csr_we) we_cycles++;
    if (csr_re) re_cycles++;
    if (csr_we && csr_ready) wr_log.push_back(csr_addr);
    if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) grant_log.push_back(1'b1);
    if (axi.S_AXI_ARVALID && axi.S_AXI_ARREADY) grant_log.push_back(1'b0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic aw, input logic w, input logic ar,
                               input logic [15:0] awaddr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [15:0] araddr);
    axi.S_AXI_AWVALID = aw;
    axi.S_AXI_WVALID  = w;
    axi.S_AXI_ARVALID = ar;
    axi.S_AXI_AWADDR  = awaddr;
    axi.S_AXI_WDATA   = wdata;
    axi.S_AXI_WSTRB   = wstrb;
    axi.S_AXI_ARADDR  = araddr;
  endtask

  task automatic applyReset();
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  // Returns the response and the number of cycles from the grant cycle to BVALID
  task automatic axiWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output int lat);
    int n;
    applyStimulus(1'b1, 1'b1, 1'b0, addr, data, strb, 16'h0);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!axi.S_AXI_AWREADY && n < 50);
    checkOutput("wr_grant_seen", axi.S_AXI_AWREADY, 1);
    lat = 0;
    do begin
      @(negedge ACLK); lat++;
      if (lat == 1) applyStimulus(1'b0, 1'b0, 1'b0, addr, data, strb, 16'h0);
    end while (!axi.S_AXI_BVALID && lat < 50);
    resp = axi.S_AXI_BRESP;
    axi.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axiRead(input logic [15:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, addr);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!axi.S_AXI_ARREADY && n < 50);
    checkOutput("rd_grant_seen", axi.S_AXI_ARREADY, 1);
    lat = 0;
    do begin
      @(negedge ACLK); lat++;
      if (lat == 1) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, addr);
    end while (!axi.S_AXI_RVALID && lat < 50);
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    axi.S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;
    int          base;
    int          we0;
    int          re0;
    int          n;
    int          wgr;
    int          rgr;

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 16'h0);
    axi.S_AXI_AWPROT = 3'b000;
    axi.S_AXI_ARPROT = 3'b000;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_RREADY = 1'b0;

    #2;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    checkOutput("rst_awready", axi.S_AXI_AWREADY, 0);
    checkOutput("rst_wready", axi.S_AXI_WREADY, 0);
    checkOutput("rst_arready", axi.S_AXI_ARREADY, 0);
    checkOutput("rst_bvalid", axi.S_AXI_BVALID, 0);
    checkOutput("rst_rvalid", axi.S_AXI_RVALID, 0);
    checkOutput("rst_rdata", axi.S_AXI_RDATA, 0);
    checkOutput("rst_csr_we_re", {csr_we, csr_re}, 0);
    checkOutput("rst_csr_addr", csr_addr, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    $display("[TB] writes and readback with zero-wait CSR");
    base = wr_log.size();
    for (int i = 0; i < 4; i++) begin
      axiWrite(16'(4 * i), 32'(i + 1), 4'hF, resp, lat);
      checkOutput("wr_bresp", resp, 2'b00);
      checkOutput("wr_latency", lat, 2);
    end
    checkOutput("wr_log_count", wr_log.size() - base, 4);
    if (wr_log.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("wr_csr_addr", wr_log[base + i], 12'(i));
    end
    for (int i = 0; i < 4; i++) begin
      axiRead(16'(4 * i), rd, resp, lat);
      checkOutput("rd_rdata", rd, 32'(i + 1));
      checkOutput("rd_rresp", resp, 2'b00);
      checkOutput("rd_latency", lat, 2);
    end

    $display("[TB] AW presented alone before W");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 32'h55, 4'hF, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checkOutput("aw_alone_awready", axi.S_AXI_AWREADY, 0);
      checkOutput("aw_alone_wready", axi.S_AXI_WREADY, 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0010, 32'h55, 4'hF, 16'h0);
    @(negedge ACLK);
    checkOutput("aw_w_ready_pair", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0010, 32'h55, 4'hF, 16'h0);
    @(negedge ACLK);
    checkOutput("aw_w_ready_pulse", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b00);
    n = 0;
    while (!axi.S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
    checkOutput("aw_w_bvalid", axi.S_AXI_BVALID, 1);
    checkOutput("aw_w_bresp", axi.S_AXI_BRESP, 2'b00);
    axi.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    axi.S_AXI_BREADY = 1'b0;

    $display("[TB] simultaneous write and read, alternating grants");
    applyReset();
    base = grant_log.size();
    axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_RREADY = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0008, 32'hA5, 4'hF, 16'h0004);
    n = 0;
    wgr = 0;
    rgr = 0;
    while ((wgr < 2 || rgr < 2) && n < 200) begin
      @(negedge ACLK); n++;
      wgr = 0;
      rgr = 0;
      for (int i = base; i < grant_log.size(); i++) begin
        if (grant_log[i]) wgr++; else rgr++;
      end
      applyStimulus(wgr < 2, wgr < 2, rgr < 2, 16'h0008, 32'hA5, 4'hF, 16'h0004);
    end
    repeat (6) @(negedge ACLK);
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    checkOutput("arb_grant_count", grant_log.size() - base, 4);
    if (grant_log.size() - base >= 4) begin
      checkOutput("arb_grant0_write", grant_log[base], 1);
      checkOutput("arb_grant1_read", grant_log[base + 1], 0);
      checkOutput("arb_grant2_write", grant_log[base + 2], 1);
      checkOutput("arb_grant3_read", grant_log[base + 3], 0);
    end
    checkOutput("arb_mem_written", mem[2], 32'hA5);

    $display("[TB] out-of-range address");
    we0 = we_cycles;
    re0 = re_cycles;
    axiWrite(16'h4000, 32'hDEAD, 4'hF, resp, lat);
    checkOutput("decerr_bresp", resp, 2'b11);
    checkOutput("decerr_no_we", we_cycles - we0, 0);
    axiRead(16'h4000, rd, resp, lat);
    checkOutput("decerr_rresp", resp, 2'b11);
    checkOutput("decerr_rdata", rd, 0);
    checkOutput("decerr_no_re", re_cycles - re0, 0);

    $display("[TB] write with empty strobe");
    we0 = we_cycles;
    axiWrite(16'h0000, 32'hFFFF_FFFF, 4'h0, resp, lat);
    checkOutput("nostrb_bresp", resp, 2'b00);
    checkOutput("nostrb_no_we", we_cycles - we0, 0);
    checkOutput("nostrb_mem_kept", mem[0], 32'h1);

    $display("[TB] CSR never ready, timeout");
    ready_mode = 1'b0;
    re0 = re_cycles;
    axiRead(16'h0008, rd, resp, lat);
    checkOutput("timeout_rresp", resp, 2'b10);
    checkOutput("timeout_rdata", rd, 0);
    checkOutput("timeout_re_cycles", re_cycles - re0, 8);
    ready_mode = 1'b1;

    $display("[TB] CSR access fault");
    err_mode = 1'b1;
    axiWrite(16'h0014, 32'h77, 4'hF, resp, lat);
    checkOutput("err_bresp", resp, 2'b10);
    axiRead(16'h0004, rd, resp, lat);
    checkOutput("err_rresp", resp, 2'b10);
    err_mode = 1'b0;

    $display("[TB] reset while read response pending");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 16'h000C);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!axi.S_AXI_ARREADY && n < 50);
    @(negedge ACLK);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 16'h000C);
    n = 0;
    while (!axi.S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
    checkOutput("midrst_rvalid_before", axi.S_AXI_RVALID, 1);
    ARESETN = 1'b0;
    #1;
    checkOutput("midrst_rvalid_cleared", axi.S_AXI_RVALID, 0);
    checkOutput("midrst_csr_re", csr_re, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    axiRead(16'h000C, rd, resp, lat);
    checkOutput("postrst_rdata", rd, 32'h4);
    checkOutput("postrst_rresp", resp, 2'b00);
    checkOutput("postrst_latency", lat, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmcsr_axil_bridge.md
Name: mmcsr_axil_bridge

Overview:
AXI4-Lite slave front end for the memory-mapped CSR block. It terminates AXI4-Lite read and write transactions from the system interconnect (VIP master in simulation). It converts each one into a single held request on a simple CSR-file port, then returns the response. It sits directly downstream of the AXI4-Lite master and directly upstream of the CSR register file.

Parameters:
C_S_AXI_ADDR_WIDTH, 16, AXI byte-address width; must be at least CSR_ADDR_WIDTH+2.
C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
CSR_ADDR_WIDTH, 12, CSR index width; index = addr[CSR_ADDR_WIDTH+1:2].
TIMEOUT_CYCLES, 64, maximum wait for csr_ready before a forced SLVERR; range 2..255.

Ports:
ACLK in 1 clock
ARESETN in 1 asynchronous active-low reset
S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH write address
S_AXI_AWPROT in 3 ignored
S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1
S_AXI_WDATA in 32 / S_AXI_WSTRB in 4
S_AXI_WVALID in 1 / S_AXI_WREADY out 1
S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1
S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH / S_AXI_ARPROT in 3 (ignored)
S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1
S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1
csr_addr out CSR_ADDR_WIDTH CSR index
csr_wdata out 32 / csr_wstrb out 4
csr_we out 1 write request / csr_re out 1 read request
csr_ready in 1 request completes this cycle
csr_rdata in 32 read data, valid with csr_ready
csr_err in 1 access fault, valid with csr_ready

Behaviour:
- One clock (ACLK). Reset is asynchronous and active-low (ARESETN). All outputs are registered.
- Reset values: every valid, ready, csr_we and csr_re is 0; BRESP, RRESP, RDATA, csr_addr, csr_wdata and csr_wstrb are 0. FSM goes to IDLE. Priority flag prefers write.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP. Only one transaction is outstanding at a time.
- IDLE, write candidate: AWVALID and WVALID are both high.
- IDLE, read candidate: ARVALID is high.
- IDLE, both candidates present: grant the side opposite to the last granted side. After reset, write wins.
- Grant cycle: assert the matching ready(s) for exactly one cycle, and latch addr, wdata and wstrb.
  - AWREADY and WREADY are always asserted together. A lone AW or lone W is never accepted.
- Decode, upper address bits nonzero (above CSR_ADDR_WIDTH+1): go directly to the RESP state with resp=DECERR (2'b11), RDATA=0. No CSR request is issued.
- Decode, write with WSTRB==0: go directly to WR_RESP with OKAY and no CSR request.
- Otherwise go to WR_REQ or RD_REQ.
- WR_REQ / RD_REQ: hold csr_we or csr_re high with stable csr_addr, csr_wdata and csr_wstrb until the cycle csr_ready=1.
  - In that cycle, capture csr_rdata (reads) and resp = csr_err ? SLVERR (2'b10) : OKAY.
  - Drop the request next cycle and enter the RESP state.
  - Earliest path: grant at cycle N, request visible at N+1, csr_ready at N+1, BVALID/RVALID at N+2.
- Timeout: the request counter starts at 0 on request entry and increments each cycle without csr_ready.
  - When the count reaches TIMEOUT_CYCLES-1 without csr_ready, drop the request and respond SLVERR with RDATA=0.
  - A csr_ready arriving in that same cycle wins, and its normal response is used.
- WR_RESP / RD_RESP: hold BVALID or RVALID with stable BRESP, or RRESP plus RDATA, until the ready is sampled high. Then return to IDLE.
  - No new grant is made in the handshake cycle. The next grant comes one cycle later.
- AWPROT and ARPROT are ignored.
- Reset asserted mid-transaction: everything clears immediately. Any in-flight request and response are discarded with no CSR side effect beyond that point.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, with a CSR model that has ready=1 the same cycle. Read them back. -> csr_addr 0..3 in order, each BRESP=OKAY, RDATA=0x1..0x4, each RRESP=OKAY, BVALID exactly 2 cycles after the AW/W handshake.
- Present AW at cycle 0 and W at cycle 3. -> AWREADY stays low until cycle 3. AWREADY and WREADY pulse together at cycle 3.
- Hold AW+W (addr 0x8, 0xA5) and AR (addr 0x4) valid together, twice back-to-back. -> write granted first, then read, then write, then read.
- Address 0x4000 (bit 14 set). -> DECERR, csr_we and csr_re never assert.
- Write with WSTRB=0. -> OKAY, csr_we never asserts.
- CSR model keeps csr_ready low, TIMEOUT_CYCLES=8. -> csr_re held exactly 8 cycles, then RRESP=SLVERR, RDATA=0.
- Same setup with csr_err=1 on ready. -> SLVERR.
- Deassert ARESETN while RVALID is high and RREADY is low. -> RVALID drops immediately. The next read after reset behaves normally.
